img_pixel_tx: RTL and testbench

IMG_PIXEL_TX -- requirements
Module: img_pixel_tx

---
 rtl/img_pixel_tx_pkg.sv | 27 ++
 rtl/img_pixel_tx_word_fifo.sv | 61 ++++++
 rtl/img_pixel_tx.sv | 125 ++++++++++++
 tb/tb_img_pixel_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pixel_tx_pkg.sv
// Shared constants, state encoding and pixel mapping for the image pixel transmitter.
// Optional feature: define PIX_INVERT_EN to emit 255 minus each buffered pixel.
package img_pixel_tx_pkg;

  localparam int unsigned IMG_W      = 28;
  localparam int unsigned IMG_PIXELS = IMG_W * IMG_W;
  localparam int unsigned ADDR_W     = 10;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned PIX_W      = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } tx_state_t;

  // Maps a buffered pixel to the value written to image memory.
  function automatic logic [PIX_W-1:0] pix_map(input logic [PIX_W-1:0] p);
`ifdef PIX_INVERT_EN
    return 8'hFF - p;
`else
    return p;
`endif
  endfunction

endpackage

// File: rtl/img_pixel_tx_word_fifo.sv
// Word buffer between the host and the pixel unpacker. The head word is read
// straight from the storage registers, so a pop consumes it in the same cycle.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  // Flags, accept qualifiers and head-word read.
  always_comb begin
    full    = (count == (PW+1)'(DEPTH));
    empty   = (count == '0);
    rd_ok   = rd && !empty;
    wr_ok   = wr && (!full || rd_ok);
    rd_data = mem[rp];
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        mem[wp] <= wr_data;
        wp      <= wp + PW'(1);
      end
      if (rd_ok) begin
        rp <= rp + PW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/img_pixel_tx.sv
// Image pixel transmitter: buffers packed 32-bit host words and writes them to
// image memory one 8-bit pixel per accepted cycle, lane 0 (bits [7:0]) first.
// Optional feature: define PIX_INVERT_EN to write 255 minus each pixel.
module img_pixel_tx
  import img_pixel_tx_pkg::*;
#(
  parameter int unsigned IMG_PIXELS = img_pixel_tx_pkg::IMG_PIXELS,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        host_wr,
  input  logic [31:0] host_data,
  output logic        host_full,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [7:0]  mem_data,
  output logic        busy,
  output logic        done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  tx_state_t         state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [1:0]        lane, lane_n;
  logic [WORD_W-1:0] word, word_n;
  logic [WORD_W-1:0] head;
  logic              pop;
  logic              empty;
  logic              fifo_wr;

  // Host words arriving while idle are dropped before reaching the buffer.
  always_comb begin
    fifo_wr = host_wr && (state != IDLE);
  end

  word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr      (fifo_wr),
    .wr_data (host_data),
    .rd      (pop),
    .rd_data (head),
    .full    (host_full),
    .empty   (empty)
  );

  // State, address counter, lane index and unpack register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      addr  <= '0;
      lane  <= '0;
      word  <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      lane  <= lane_n;
      word  <= word_n;
    end
  end

  // Next-state logic: pops happen on LOAD and on lane-3 completion for a bubble-free stream.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    lane_n  = lane;
    word_n  = word;
    pop     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = LOAD;
          addr_n  = '0;
        end
      end
      LOAD: begin
        if (!empty) begin
          pop     = 1'b1;
          word_n  = head;
          lane_n  = '0;
          state_n = SEND;
        end
      end
      SEND: begin
        if (mem_ready) begin
          if (addr == LAST_ADDR) begin
            // Any lanes left in the final word are discarded.
            state_n = DONE;
          end else begin
            addr_n = addr + ADDR_W'(1);
            if (lane == 2'd3) begin
              lane_n = '0;
              if (!empty) begin
                pop    = 1'b1;
                word_n = head;
              end else begin
                state_n = LOAD;
              end
            end else begin
              lane_n = lane + 2'd1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs decoded from state; data is forced to zero whenever no write is offered.
  always_comb begin
    mem_we   = (state == SEND);
    mem_addr = addr;
    mem_data = (state == SEND) ? pix_map(word[{lane, 3'b000} +: PIX_W]) : '0;
    busy     = (state == LOAD) || (state == SEND);
    done     = (state == DONE);
  end

endmodule

// File: tb/tb_img_pixel_tx.sv
// Directed bench for img_pixel_tx: a cycle-by-cycle vector table followed by
// hand-written sequences for buffer full, full images, stalls and reset abort.
module tb_img_pixel_tx;

  localparam int NPIX   = 784;
  localparam int NWORDS = 196;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        host_wr = 1'b0;
  logic [31:0] host_data = '0;
  logic        mem_ready = 1'b0;
  logic        host_full;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_data;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  img_pixel_tx #(
    .IMG_PIXELS (784),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .host_wr   (host_wr),
    .host_data (host_data),
    .host_full (host_full),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        start;
    logic        wr;
    logic [31:0] data;
    logic        ready;
    logic        we;
    logic [9:0]  addr;
    logic [7:0]  pdata;
    logic        busy;
    logic        done;
    logic        full;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t v(input bit s, input bit w, input logic [31:0] d, input bit r,
                             input bit we, input int a, input int pd, input bit b,
                             input bit dn, input bit f);
    vec_t t;
    t.start = s; t.wr = w; t.data = d; t.ready = r;
    t.we = we; t.addr = 10'(a); t.pdata = 8'(pd); t.busy = b; t.done = dn; t.full = f;
    return t;
  endfunction

  // Expected memory value for a buffered pixel.
  function automatic logic [7:0] px(input logic [7:0] p);
`ifdef PIX_INVERT_EN
    return 8'hFF - p;
`else
    return p;
`endif
  endfunction

  function automatic logic [7:0] pix(input int n);
    return 8'((n * 37) + 11);
  endfunction

  function automatic logic [31:0] mk_word(input int k);
    return {pix(4*k+3), pix(4*k+2), pix(4*k+1), pix(4*k)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},   {31'd0, mem_we},    32'd0);
    chk({tag, "_addr"}, {22'd0, mem_addr},  32'd0);
    chk({tag, "_data"}, {24'd0, mem_data},  32'd0);
    chk({tag, "_busy"}, {31'd0, busy},      32'd0);
    chk({tag, "_done"}, {31'd0, done},      32'd0);
    chk({tag, "_full"}, {31'd0, host_full}, 32'd0);
  endtask

  // Starts an image and streams words until `limit` writes complete (bounded).
  task automatic run_image(input bit rnd, input int limit);
    int k, n, cyc, first_c, last_c;
    bit stalled;
    logic [9:0] sa;
    logic [7:0] sd;
    k = 0; n = 0; cyc = 0; first_c = -1; last_c = 0; stalled = 1'b0; sa = '0; sd = '0;
    @(negedge clk);
    start = 1'b1; host_wr = 1'b0; mem_ready = 1'b1;
    while (n < limit && cyc < 20000) begin
      @(negedge clk);
      start     = 1'b0;
      mem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      host_wr   = (k < NWORDS) && !host_full;
      host_data = mk_word(k);
      if (host_wr) k++;
      #1;
      if (stalled) begin
        chk("hold_addr", {22'd0, mem_addr}, {22'd0, sa});
        chk("hold_data", {24'd0, mem_data}, {24'd0, sd});
        stalled = 1'b0;
      end
      if (mem_we) begin
        if (mem_ready) begin
          chk("addr", {22'd0, mem_addr}, n);
          chk("data", {24'd0, mem_data}, {24'd0, px(pix(n))});
          if (first_c < 0) first_c = cyc;
          last_c = cyc;
          n++;
        end else begin
          stalled = 1'b1;
          sa = mem_addr;
          sd = mem_data;
        end
      end
      cyc++;
    end
    chk("write_count", n, limit);
    if (limit == NPIX) begin
      @(negedge clk);
      host_wr = 1'b0;
      #1;
      chk("done_level", {31'd0, done},   32'd1);
      chk("done_busy",  {31'd0, busy},   32'd0);
      chk("done_we",    {31'd0, mem_we}, 32'd0);
      if (!rnd) chk("throughput", last_c - first_c, NPIX - 1);
    end
  endtask

  initial begin
    // Per-cycle vectors: inputs for the cycle and the outputs expected during it.
    tbl[0]  = v(0, 1, 32'hAAAAAAAA, 0, 0, 0, 8'h00, 0, 0, 0); // IDLE write dropped
    tbl[1]  = v(1, 0, 32'h0,        0, 0, 0, 8'h00, 0, 0, 0);
    tbl[2]  = v(0, 1, 32'h04030201, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[3]  = v(0, 1, 32'h08070605, 0, 0, 0, 8'h00, 1, 0, 0);
    tbl[4]  = v(1, 0, 32'h0,        0, 1, 0, 8'h01, 1, 0, 0); // start in SEND ignored
    tbl[5]  = v(0, 0, 32'h0,        1, 1, 0, 8'h01, 1, 0, 0);
    tbl[6]  = v(0, 0, 32'h0,        1, 1, 1, 8'h02, 1, 0, 0);
    tbl[7]  = v(0, 0, 32'h0,        0, 1, 2, 8'h03, 1, 0, 0);
    tbl[8]  = v(0, 0, 32'h0,        1, 1, 2, 8'h03, 1, 0, 0);
    tbl[9]  = v(0, 0, 32'h0,        1, 1, 3, 8'h04, 1, 0, 0);
    tbl[10] = v(0, 0, 32'h0,        1, 1, 4, 8'h05, 1, 0, 0);
    tbl[11] = v(1, 0, 32'h0,        1, 1, 5, 8'h06, 1, 0, 0);
    tbl[12] = v(0, 0, 32'h0,        1, 1, 6, 8'h07, 1, 0, 0);
    tbl[13] = v(0, 0, 32'h0,        1, 1, 7, 8'h08, 1, 0, 0);
    tbl[14] = v(0, 0, 32'h0,        1, 0, 8, 8'h00, 1, 0, 0);
    tbl[15] = v(0, 1, 32'h0C0B0A09, 1, 0, 8, 8'h00, 1, 0, 0);
    tbl[16] = v(0, 0, 32'h0,        1, 0, 8, 8'h00, 1, 0, 0);
    tbl[17] = v(0, 0, 32'h0,        1, 1, 8, 8'h09, 1, 0, 0);

    #2;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      start     = tbl[i].start;
      host_wr   = tbl[i].wr;
      host_data = tbl[i].data;
      mem_ready = tbl[i].ready;
      #1;
      chk($sformatf("v%0d_we", i),   {31'd0, mem_we},    {31'd0, tbl[i].we});
      chk($sformatf("v%0d_addr", i), {22'd0, mem_addr},  {22'd0, tbl[i].addr});
      chk($sformatf("v%0d_data", i), {24'd0, mem_data},
          {24'd0, (tbl[i].we ? px(tbl[i].pdata) : 8'h00)});
      chk($sformatf("v%0d_busy", i), {31'd0, busy},      {31'd0, tbl[i].busy});
      chk($sformatf("v%0d_done", i), {31'd0, done},      {31'd0, tbl[i].done});
      chk($sformatf("v%0d_full", i), {31'd0, host_full}, {31'd0, tbl[i].full});
    end
    start = 1'b0; host_wr = 1'b0;

    // Asynchronous reset mid-transfer clears outputs immediately.
    reset = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Buffer full: the first word moves to the unpack register, four more fill
    // the buffer, and the word after that is dropped.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("full_before_w%0d", i), {31'd0, host_full}, {31'd0, (i == 5)});
      host_wr   = 1'b1;
      host_data = mk_word(i);
      @(negedge clk);
    end
    host_wr = 1'b0;
    #1;
    chk("full_after_drop", {31'd0, host_full}, 32'd1);
    mem_ready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      chk($sformatf("fill_we%0d", j),   {31'd0, mem_we},   32'd1);
      chk($sformatf("fill_addr%0d", j), {22'd0, mem_addr}, j);
      chk($sformatf("fill_data%0d", j), {24'd0, mem_data}, {24'd0, px(pix(j))});
      @(negedge clk);
      #1;
    end
    for (int j = 0; j < 3; j++) begin
      chk("fill_drained_we",   {31'd0, mem_we}, 32'd0);
      chk("fill_drained_busy", {31'd0, busy},   32'd1);
      @(negedge clk);
      #1;
    end

    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Full image with memory always ready, then a restart from DONE with random stalls.
    run_image(1'b0, NPIX);
    run_image(1'b1, NPIX);

    // Abort at address 300, stay idle, then a fresh image from address 0.
    run_image(1'b0, 300);
    @(negedge clk);
    host_wr = 1'b0;
    #1;
    chk("at300_addr", {22'd0, mem_addr}, 32'd300);
    chk("at300_we",   {31'd0, mem_we},   32'd1);
    reset = 1'b0;
    #1;
    check_zero("rst300");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      host_wr   = 1'b1;
      host_data = mk_word(i);
      #1;
      chk("post_abort_we",   {31'd0, mem_we}, 32'd0);
      chk("post_abort_busy", {31'd0, busy},   32'd0);
    end
    host_wr = 1'b0;
    run_image(1'b0, NPIX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
